control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have the port clock, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have the port clear, input, 1 bit: the reset, asynchronous and active-low.
REQ-003 The block SHALL have the ports IR, input, 32 bits, and mem_ready, input, 1 bit; IR is the instruction register contents and mem_ready is the memory read-complete strobe.
REQ-004 The block SHALL have the outputs PCout, Zhighout, Zlowout, MDRout, HIout and LOout, 1 bit each, which are the datapath bus drive enables.
REQ-005 The block SHALL have the outputs MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zhighin and Zlowin, 1 bit each, which are the datapath register load enables.
REQ-006 The block SHALL have the outputs IncPC and Read, 1 bit each: IncPC is the PC increment request and Read is the memory read request.
REQ-007 The block SHALL have the outputs Gra, Grb, Grc, Rin and Rout, 1 bit each, which drive the select-and-encode register-file fields.
REQ-008 The block SHALL have the output opcode, 5 bits, which is the ALU operation select to the datapath.
REQ-009 The block SHALL have the outputs run, 1 bit (high while executing), and illegal, 1 bit (one-cycle pulse on an undefined opcode).

Function
REQ-010 The block SHALL be a Moore FSM with the states RST, T0, T1, T2, T3, T4, T5, T6 and HALTED, and every output SHALL be decoded from the present state and the latched IR[31:27] only.
REQ-011 The block SHALL assert each enable for exactly the clock cycles in which it occupies the state listed below, with every unlisted output at 0.
REQ-012 RST SHALL drive all outputs 0 and run 0, and SHALL go to T0 on the first edge after clear deasserts.
REQ-013 T0 SHALL assert PCout, MARin, IncPC and PCin.
REQ-014 T1 SHALL assert Read and MDRin.
REQ-015 T2 SHALL assert MDRout and IRin; on the T2 to T3 edge the block SHALL latch IR[31:27] into an internal op register.
REQ-016 For the R-type ALU ops ADD, SUB, AND, OR, SHR, SHL, ROR and ROL, T3 SHALL assert Grb, Rout and Yin.
REQ-017 For those ops, T4 SHALL assert Grc, Rout and Zlowin, and opcode SHALL equal op.
REQ-018 For those ops, T5 SHALL assert Zlowout, Gra and Rin, and the next state SHALL be T0.
REQ-019 For MUL and DIV, T3 SHALL be as for ADD, and T4 SHALL assert Grc, Rout, Zlowin and Zhighin with opcode equal to op.
REQ-020 For MUL and DIV, T5 SHALL assert Zlowout and LOin, T6 SHALL assert Zhighout and HIin, and the next state SHALL be T0.
REQ-021 For NEG and NOT, T3 SHALL assert Grb, Rout and Zlowin with opcode equal to op, T4 SHALL assert Zlowout, Gra and Rin, and the next state SHALL be T0.
REQ-022 NOP SHALL go from T2 to T0.
REQ-023 HALT SHALL go from T2 to HALTED; HALTED SHALL drive all outputs 0 and run 0 and SHALL be left only by reset.
REQ-024 An undefined opcode SHALL pulse illegal for 1 cycle in T3, assert no other enable, and then go to T0.
REQ-025 opcode SHALL be 5'b00000 in every state other than the ALU step.
REQ-026 run SHALL be 1 in T0 through T6.

Reset
REQ-027 clear low SHALL force RST immediately from any state, including mid-instruction and during a T1 wait, and SHALL clear the op register to 0.
REQ-028 No enable SHALL be asserted while clear is low.

Configuration
REQ-029 With CU_MEM_WAIT_EN defined, T1 SHALL hold Read and MDRin asserted until the edge where mem_ready is 1, then go to T2; mem_ready already high on entry SHALL give a 1-cycle T1.
REQ-030 Without CU_MEM_WAIT_EN, T1 SHALL last exactly 1 cycle and mem_ready SHALL be ignored.

Structure
REQ-031 A shared package SHALL hold the 5-bit op constants ADD=00011, SUB=00100, AND=00101, OR=00110, SHR=00111, SHL=01001, ROR=01010, ROL=01011, MUL=01111, DIV=10000, NEG=10001, NOT=10010, NOP=11010 and HALT=11011.
REQ-032 The shared package SHALL also hold the state enumeration.
REQ-033 Output decoding SHALL be a sub-module named control_decode, taking the state and op and producing all enables.

Verification
REQ-034 Release clear, then IR=32'h1891_8000 (ADD) -> the sequence RST, T0, T1, T2, T3, T4, T5, T0; opcode=00011 only in T4; Gra and Rin only in T5.
REQ-035 IR=32'h8091_8000 (DIV) -> T4 asserts Zlowin, Zhighin and opcode=10000; T5 asserts Zlowout and LOin; T6 asserts Zhighout and HIin; then T0.
REQ-036 With CU_MEM_WAIT_EN defined, mem_ready low for 3 cycles after T1 entry -> Read and MDRin held for 4 cycles, then T2.
REQ-037 IR=32'hD800_0000 (HALT) -> HALTED with run=0, held for 20 cycles; pulsing clear low then high -> RST, then T0.
REQ-038 IR=32'hF800_0000 (opcode 11111) -> illegal=1 for one cycle in T3, no enables asserted, then T0.
REQ-039 clear driven low during T5 of MUL -> all outputs 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared types for the control sequencer: states, op codes, op classes
// and the bundle of datapath control strobes.
package control_sequencer_pkg;

  typedef enum logic [3:0] {
    S_RST,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALTED
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [2:0] {
    C_ALU,
    C_MULDIV,
    C_UNARY,
    C_NOP,
    C_HALT,
    C_BAD
  } op_cls_t;

  typedef struct packed {
    logic       pc_out;
    logic       zhigh_out;
    logic       zlow_out;
    logic       mdr_out;
    logic       hi_out;
    logic       lo_out;
    logic       mar_in;
    logic       pc_in;
    logic       mdr_in;
    logic       ir_in;
    logic       y_in;
    logic       hi_in;
    logic       lo_in;
    logic       zhigh_in;
    logic       zlow_in;
    logic       inc_pc;
    logic       read;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_in;
    logic       r_out;
    logic       run;
    logic       illegal;
    logic [4:0] opcode;
  } ctrl_t;

  function automatic op_cls_t op_class(input logic [4:0] op);
    op_cls_t c;
    c = C_BAD;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: c = C_ALU;
      OP_MUL, OP_DIV:                 c = C_MULDIV;
      OP_NEG, OP_NOT:                 c = C_UNARY;
      OP_NOP:                         c = C_NOP;
      OP_HALT:                        c = C_HALT;
      default:                        c = C_BAD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Moore output decode: maps present state and latched op to the
// datapath control strobes.
module control_decode
  import control_sequencer_pkg::*;
(
  input  state_t     state,
  input  logic [4:0] op,
  output ctrl_t      ctrl
);

  op_cls_t cls;

  always_comb begin
    ctrl = '0;
    cls  = op_class(op);
    unique case (state)
      S_T0: begin
        ctrl.run    = 1'b1;
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
        ctrl.inc_pc = 1'b1;
        ctrl.pc_in  = 1'b1;
      end
      S_T1: begin
        ctrl.run    = 1'b1;
        ctrl.read   = 1'b1;
        ctrl.mdr_in = 1'b1;
      end
      S_T2: begin
        ctrl.run     = 1'b1;
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
      end
      S_T3: begin
        ctrl.run = 1'b1;
        case (cls)
          C_ALU, C_MULDIV: begin
            ctrl.grb   = 1'b1;
            ctrl.r_out = 1'b1;
            ctrl.y_in  = 1'b1;
          end
          C_UNARY: begin
            ctrl.grb     = 1'b1;
            ctrl.r_out   = 1'b1;
            ctrl.zlow_in = 1'b1;
            ctrl.opcode  = op;
          end
          C_BAD:   ctrl.illegal = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        ctrl.run = 1'b1;
        case (cls)
          C_ALU, C_MULDIV: begin
            ctrl.grc      = 1'b1;
            ctrl.r_out    = 1'b1;
            ctrl.zlow_in  = 1'b1;
            ctrl.zhigh_in = (cls == C_MULDIV);
            ctrl.opcode   = op;
          end
          C_UNARY: begin
            ctrl.zlow_out = 1'b1;
            ctrl.gra      = 1'b1;
            ctrl.r_in     = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        ctrl.run = 1'b1;
        case (cls)
          C_ALU: begin
            ctrl.zlow_out = 1'b1;
            ctrl.gra      = 1'b1;
            ctrl.r_in     = 1'b1;
          end
          C_MULDIV: begin
            ctrl.zlow_out = 1'b1;
            ctrl.lo_in    = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        ctrl.run       = 1'b1;
        ctrl.zhigh_out = 1'b1;
        ctrl.hi_in     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer FSM. Define CU_MEM_WAIT_EN to stretch
// T1 until mem_ready; otherwise T1 is a single cycle.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        Zhighin,
  output logic        Zlowin,
  output logic        IncPC,
  output logic        Read,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic [4:0]  opcode,
  output logic        run,
  output logic        illegal
);

  state_t     state;
  state_t     state_next;
  logic [4:0] op;
  op_cls_t    cls_ir;
  op_cls_t    cls_op;
  ctrl_t      ctrl;

`ifdef CU_MEM_WAIT_EN
  logic unused_ir;
  assign unused_ir = ^IR[26:0];
`else
  logic unused_in;
  assign unused_in = ^{IR[26:0], mem_ready};
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_RST;
      op    <= '0;
    end else begin
      state <= state_next;
      if (state == S_T2 && state_next == S_T3)
        op <= IR[31:27];
    end
  end

  // T2 branches on the live IR; later steps use the latched op
  always_comb begin
    state_next = state;
    cls_ir     = op_class(IR[31:27]);
    cls_op     = op_class(op);
    unique case (state)
      S_RST: state_next = S_T0;
      S_T0:  state_next = S_T1;
`ifdef CU_MEM_WAIT_EN
      S_T1:  if (mem_ready) state_next = S_T2;
`else
      S_T1:  state_next = S_T2;
`endif
      S_T2: begin
        case (cls_ir)
          C_NOP:   state_next = S_T0;
          C_HALT:  state_next = S_HALTED;
          default: state_next = S_T3;
        endcase
      end
      S_T3: state_next = (cls_op == C_BAD)    ? S_T0 : S_T4;
      S_T4: state_next = (cls_op == C_UNARY)  ? S_T0 : S_T5;
      S_T5: state_next = (cls_op == C_MULDIV) ? S_T6 : S_T0;
      S_T6: state_next = S_T0;
      S_HALTED: state_next = S_HALTED;
      default:  state_next = S_RST;
    endcase
  end

  control_decode u_decode (
    .state (state),
    .op    (op),
    .ctrl  (ctrl)
  );

  assign PCout    = ctrl.pc_out;
  assign Zhighout = ctrl.zhigh_out;
  assign Zlowout  = ctrl.zlow_out;
  assign MDRout   = ctrl.mdr_out;
  assign HIout    = ctrl.hi_out;
  assign LOout    = ctrl.lo_out;
  assign MARin    = ctrl.mar_in;
  assign PCin     = ctrl.pc_in;
  assign MDRin    = ctrl.mdr_in;
  assign IRin     = ctrl.ir_in;
  assign Yin      = ctrl.y_in;
  assign HIin     = ctrl.hi_in;
  assign LOin     = ctrl.lo_in;
  assign Zhighin  = ctrl.zhigh_in;
  assign Zlowin   = ctrl.zlow_in;
  assign IncPC    = ctrl.inc_pc;
  assign Read     = ctrl.read;
  assign Gra      = ctrl.gra;
  assign Grb      = ctrl.grb;
  assign Grc      = ctrl.grc;
  assign Rin      = ctrl.r_in;
  assign Rout     = ctrl.r_out;
  assign opcode   = ctrl.opcode;
  assign run      = ctrl.run;
  assign illegal  = ctrl.illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction expected strobe
// sequences built from the op class, compared every cycle.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] IR;
  logic        mem_ready;
  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
  logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin;
  logic IncPC, Read, Gra, Grb, Grc, Rin, Rout, run, illegal;
  logic [4:0] opcode;

  control_sequencer dut (
    .clock(clock), .clear(clear), .IR(IR), .mem_ready(mem_ready),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .MDRout(MDRout), .HIout(HIout), .LOout(LOout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .Zhighin(Zhighin),
    .Zlowin(Zlowin), .IncPC(IncPC), .Read(Read), .Gra(Gra),
    .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .opcode(opcode), .run(run), .illegal(illegal)
  );

  always #5 clock = ~clock;

  logic [28:0] obs;
  assign obs = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
                MARin, PCin, MDRin, IRin, Yin, HIin, LOin,
                Zhighin, Zlowin, IncPC, Read, Gra, Grb, Grc,
                Rin, Rout, run, illegal, opcode};

  localparam logic [28:0] PCOUT   = 29'd1 << 28;
  localparam logic [28:0] ZHOUT   = 29'd1 << 27;
  localparam logic [28:0] ZLOUT   = 29'd1 << 26;
  localparam logic [28:0] MDROUT  = 29'd1 << 25;
  localparam logic [28:0] MARIN   = 29'd1 << 22;
  localparam logic [28:0] PCIN    = 29'd1 << 21;
  localparam logic [28:0] MDRIN   = 29'd1 << 20;
  localparam logic [28:0] IRIN    = 29'd1 << 19;
  localparam logic [28:0] YIN     = 29'd1 << 18;
  localparam logic [28:0] HIIN    = 29'd1 << 17;
  localparam logic [28:0] LOIN    = 29'd1 << 16;
  localparam logic [28:0] ZHIN    = 29'd1 << 15;
  localparam logic [28:0] ZLIN    = 29'd1 << 14;
  localparam logic [28:0] INCPC   = 29'd1 << 13;
  localparam logic [28:0] READ    = 29'd1 << 12;
  localparam logic [28:0] GRA     = 29'd1 << 11;
  localparam logic [28:0] GRB     = 29'd1 << 10;
  localparam logic [28:0] GRC     = 29'd1 << 9;
  localparam logic [28:0] RIN     = 29'd1 << 8;
  localparam logic [28:0] ROUT    = 29'd1 << 7;
  localparam logic [28:0] RUN     = 29'd1 << 6;
  localparam logic [28:0] ILLEG   = 29'd1 << 5;

  int n_tests = 0;
  int n_fail  = 0;
  logic [28:0] exp_q[$];

  task automatic check(input string tag, input logic [28:0] got,
                       input logic [28:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // 0 alu, 1 mul/div, 2 unary, 3 nop, 4 halt, 5 undefined
  function automatic int kind(input logic [4:0] o);
    case (o)
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b00111, 5'b01001, 5'b01010, 5'b01011: return 0;
      5'b01111, 5'b10000: return 1;
      5'b10001, 5'b10010: return 2;
      5'b11010: return 3;
      5'b11011: return 4;
      default:  return 5;
    endcase
  endfunction

  function automatic void build(input logic [4:0] o, input int w);
    int k;
    logic [28:0] opv;
    k = kind(o);
    opv = {24'd0, o};
    exp_q.delete();
    exp_q.push_back(PCOUT | MARIN | INCPC | PCIN | RUN);
    repeat (w + 1) exp_q.push_back(READ | MDRIN | RUN);
    exp_q.push_back(MDROUT | IRIN | RUN);
    case (k)
      0: begin
        exp_q.push_back(GRB | ROUT | YIN | RUN);
        exp_q.push_back(GRC | ROUT | ZLIN | RUN | opv);
        exp_q.push_back(ZLOUT | GRA | RIN | RUN);
      end
      1: begin
        exp_q.push_back(GRB | ROUT | YIN | RUN);
        exp_q.push_back(GRC | ROUT | ZLIN | ZHIN | RUN | opv);
        exp_q.push_back(ZLOUT | LOIN | RUN);
        exp_q.push_back(ZHOUT | HIIN | RUN);
      end
      2: begin
        exp_q.push_back(GRB | ROUT | ZLIN | RUN | opv);
        exp_q.push_back(ZLOUT | GRA | RIN | RUN);
      end
      4: repeat (20) exp_q.push_back('0);
      5: exp_q.push_back(RUN | ILLEG);
      default: ;
    endcase
  endfunction

  task automatic run_instr(input logic [31:0] ir, input int w,
                           input int abort_at);
    build(ir[31:27], w);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clock);
      check($sformatf("op%b_w%0d_c%0d", ir[31:27], w, i),
            obs, exp_q[i]);
      if (i == 0) IR = ir;
`ifdef CU_MEM_WAIT_EN
      if (i >= 1 && i <= 1 + w) mem_ready = (i - 1 >= w);
      else mem_ready = 1'($urandom);
`else
      mem_ready = 1'($urandom);
`endif
      if (i == abort_at) begin
        #1 clear = 1'b0;
        #1 check("async_clr", obs, '0);
        @(negedge clock);
        check("clr_hold", obs, '0);
        clear = 1'b1;
        return;
      end
    end
  endtask

  logic [4:0] o;
  int w;

  initial begin
    clear = 1'b0;
    IR = '0;
    mem_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("reset", obs, '0);
    clear = 1'b1;
    #1 check("rst_state", obs, '0);

    run_instr(32'h1891_8000, 0, -1);
    run_instr(32'h8091_8000, 0, -1);
    run_instr(32'hF800_0000, 0, -1);
`ifdef CU_MEM_WAIT_EN
    run_instr(32'h1891_8000, 3, -1);
`endif
    run_instr({5'b11010, 27'd0}, 0, -1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        o = 5'($urandom);
        while (kind(o) != 5) o = 5'($urandom);
      end else begin
        o = 5'($urandom);
        while (kind(o) == 4 || kind(o) == 5) o = 5'($urandom);
      end
`ifdef CU_MEM_WAIT_EN
      w = $urandom_range(0, 3);
`else
      w = 0;
`endif
      run_instr({o, 27'($urandom)}, w, -1);
    end

    run_instr({5'b01111, 27'h123}, 0, 5);
    run_instr(32'h1891_8000, 0, -1);

    run_instr(32'hD800_0000, 0, -1);
    @(negedge clock);
    check("halted_stay", obs, '0);
    clear = 1'b0;
    #1 check("halt_clr", obs, '0);
    @(negedge clock);
    clear = 1'b1;
    run_instr(32'h8091_8000, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
